// File: rtl/imm_gen_pipe.sv
// Immediate generator with a 2-entry output FIFO.
// Each accepted instruction is decoded to (imm, fmt, target, illegal) and then buffered.
// Head fields read as zero whenever the FIFO is empty.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [XLEN-1:0]  pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       fmt,
  output logic [XLEN-1:0]  target,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    FmtR = 3'd0,
    FmtI = 3'd1,
    FmtS = 3'd2,
    FmtB = 3'd3,
    FmtU = 3'd4,
    FmtJ = 3'd5,
    FmtX = 3'd7
  } fmt_e;

  // Decode-stage signals.
  fmt_e            dec_fmt;
  logic            dec_pcrel;
  logic [31:0]     dec_imm32;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_tgt;
  logic            dec_illegal;

  // FIFO state.
  logic [XLEN-1:0] imm_mem [2];
  logic [XLEN-1:0] tgt_mem [2];
  logic [2:0]      fmt_mem [2];
  logic [1:0]      ill_mem;
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      count_q, count_d;
  logic [CNT_W-1:0] illegal_cnt_q;

  logic push, pop;

  // Opcode classification; pc-relative targets only for branches, JAL and AUIPC.
  always_comb begin
    dec_fmt   = FmtX;
    dec_pcrel = 1'b0;
    case (inst[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: dec_fmt = FmtI;
      7'b0100011: dec_fmt = FmtS;
      7'b1100011: begin
        dec_fmt   = FmtB;
        dec_pcrel = 1'b1;
      end
      7'b0110111: dec_fmt = FmtU;
      7'b0010111: begin
        dec_fmt   = FmtU;
        dec_pcrel = 1'b1;
      end
      7'b1101111: begin
        dec_fmt   = FmtJ;
        dec_pcrel = 1'b1;
      end
      7'b0110011: dec_fmt = FmtR;
      default:    dec_fmt = FmtX;
    endcase
  end

  // Immediate assembly at 32 bits, then sign-extension to XLEN and target add.
  always_comb begin
    dec_imm32 = '0;
    case (dec_fmt)
      FmtI: dec_imm32 = {{20{inst[31]}}, inst[31:20]};
      FmtS: dec_imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FmtB: dec_imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FmtU: dec_imm32 = {inst[31:12], 12'b0};
      FmtJ: dec_imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: dec_imm32 = '0;
    endcase
    dec_imm     = XLEN'($signed(dec_imm32));
    dec_tgt     = dec_pcrel ? (pc + dec_imm) : '0;
    dec_illegal = (dec_fmt == FmtX);
  end

  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Occupancy next state; flush is handled in the register block.
  always_comb begin
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // Pointers, occupancy and saturating illegal counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      illegal_cnt_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
      if (push && dec_illegal && (illegal_cnt_q != {CNT_W{1'b1}})) begin
        illegal_cnt_q <= illegal_cnt_q + 1'b1;
      end
    end
  end

  // Entry storage; contents are don't-care until written, outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      imm_mem[wr_ptr_q] <= dec_imm;
      tgt_mem[wr_ptr_q] <= dec_tgt;
      fmt_mem[wr_ptr_q] <= dec_fmt;
      ill_mem[wr_ptr_q] <= dec_illegal;
    end
  end

  // Head presentation, forced to zero when empty.
  always_comb begin
    imm     = '0;
    fmt     = 3'd0;
    target  = '0;
    illegal = 1'b0;
    if (out_valid) begin
      imm     = imm_mem[rd_ptr_q];
      fmt     = fmt_mem[rd_ptr_q];
      target  = tgt_mem[rd_ptr_q];
      illegal = ill_mem[rd_ptr_q];
    end
  end

  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, legal values 32 and 64, setting immediate/PC/target width.
REQ-002 SHALL have parameter CNT_W, default 16, setting the illegal-instruction counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port flush, input, 1, synchronous discard of all buffered entries.
REQ-006 SHALL have port in_valid, input, 1, upstream has an instruction.
REQ-007 SHALL have port in_ready, output, 1, block can accept this cycle.
REQ-008 SHALL have port inst, input, 32, instruction word.
REQ-009 SHALL have port pc, input, XLEN, address of inst.
REQ-010 SHALL have port out_valid, output, 1, head entry valid.
REQ-011 SHALL have port out_ready, input, 1, downstream consumes head.
REQ-012 SHALL have port imm, output, XLEN, sign-extended immediate of head.
REQ-013 SHALL have port fmt, output, 3, format code of head: R=0, I=1, S=2, B=3, U=4, J=5, unknown=7.
REQ-014 SHALL have port target, output, XLEN, pc+imm for B, J and AUIPC; 0 otherwise.
REQ-015 SHALL have port illegal, output, 1, head opcode unrecognised.
REQ-016 SHALL have port illegal_cnt, output, CNT_W, saturating count of accepted illegal instructions.

Function
REQ-017 SHALL decode the full opcode inst[6:0]: 0000011, 0010011, 1100111, 1110011 -> I; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J; 0110011 -> R; anything else -> unknown.
REQ-018 SHALL form immediates: I = inst[31:20]; S = {inst[31:25],inst[11:7]}; B = {inst[31],inst[7],inst[30:25],inst[11:8],0}; U = {inst[31:12],12'b0}; J = {inst[31],inst[19:12],inst[20],inst[30:21],0}; all sign-extended from bit 31 of inst to XLEN.
REQ-019 SHALL output imm=0 for R and unknown formats, with illegal=1 only for unknown.
REQ-020 SHALL compute target as pc+imm modulo 2^XLEN (wrap-around, no carry out) at decode time and store it with the entry.
REQ-021 SHALL buffer decoded entries in a 2-entry FIFO (fields imm, fmt, target, illegal); a transfer occurs when valid and ready are both high.
REQ-022 SHALL drive in_ready = (count < 2) and out_valid = (count != 0), both purely from registered state.
REQ-023 SHALL present an accepted instruction on the outputs no earlier than the cycle after acceptance (latency 1 when empty).
REQ-024 SHALL, on simultaneous push and pop at count 1, keep count at 1 with the new entry becoming head next cycle.
REQ-025 SHALL hold head outputs stable while out_valid=1 and out_ready=0.
REQ-026 SHALL, on flush, set count to 0 next cycle; flush overrides a same-cycle push and pop, and the flushed push is not counted.
REQ-027 SHALL increment illegal_cnt on each accepted unknown-opcode instruction not coincident with flush, saturating at all-ones.
REQ-028 SHALL drive imm, fmt, target, illegal to 0 when out_valid=0.

Reset
REQ-029 SHALL, on rst_n low, immediately clear count, FIFO pointers, and illegal_cnt; out_valid=0, in_ready=1 once reset is released.
REQ-030 SHALL, on reset assertion mid-operation, discard all buffered entries with no partial output.

Verification
REQ-031 SHALL verify I-type: inst 0xFFF00093, pc 0x0 -> imm 0xFFFFFFFF, fmt 1, target 0, illegal 0, out_valid one cycle after accept.
REQ-032 SHALL verify B-type: inst 0xFE000EE3, pc 0x100 -> imm 0xFFFFFFFC, fmt 3, target 0x000000FC; U-type inst 0x123450B7 -> imm 0x12345000, fmt 4, target 0.
REQ-033 SHALL verify J-type: inst 0x0080006F, pc 0x200 -> imm 0x8, fmt 5, target 0x208; with XLEN=64 and pc 0xFFFFFFFFFFFFFFFC, target wraps to 0x4.
REQ-034 SHALL verify backpressure: out_ready=0, three back-to-back pushes -> first two accepted, in_ready=0 thereafter, third held upstream; then out_ready=1 drains in order.
REQ-035 SHALL verify illegal: inst 0x0000007F accepted -> illegal 1, imm 0, fmt 7, illegal_cnt 0->1; with CNT_W=2, five such pushes give illegal_cnt 3.
REQ-036 SHALL verify flush/reset: two entries buffered, flush with in_valid=1 -> count 0, out_valid 0 next cycle, illegal_cnt unchanged; rst_n low mid-stream -> out_valid 0 immediately.
